// File: rtl/aes_stream_sequencer.sv
// aes_stream_sequencer
// Word-serial valid/ready front end for a 128-bit AES block core. Collects
// BLK_W/WORD_W input words MS-first, launches the core, waits for its done
// pulse and streams the result back out MS word first.
// Optional feature macro: AES_CBC_EN adds iv_in/iv_we and a CBC chain register.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_LOAD   | accepting input words into the block image (s_ready=1)
//   ST_START  | one-cycle core_start pulse
//   ST_WAIT   | waiting for core_done; core_din held stable
//   ST_UNLOAD | presenting result words on m_data (m_valid=1)
module aes_stream_sequencer #(
    parameter int WORD_W = 32,
    parameter int BLK_W  = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_decrypt,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
`ifdef AES_CBC_EN
    input  logic [BLK_W-1:0]  iv_in,
    input  logic              iv_we,
`endif
    output logic              core_start,
    output logic              core_decrypt,
    output logic [BLK_W-1:0]  core_din,
    input  logic              core_done,
    input  logic [BLK_W-1:0]  core_dout,
    output logic [CNT_W-1:0]  blk_count
);

    localparam int N     = BLK_W / WORD_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLK_W-1:0]   din_q, din_d;
    logic [BLK_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dec_q, dec_d;
    logic [1:0]         flush_q, flush_d;
    logic [BLK_W-1:0]   blk_word;
    logic               s_fire;
    logic               m_fire;
    logic               drop_done;
    logic               word_mode;
`ifdef AES_CBC_EN
    logic [BLK_W-1:0]   chain_q, chain_d;
`endif

    // handshake qualifiers and the block image with the incoming word merged in
    always_comb begin
        s_fire    = s_valid && (state_q == ST_LOAD);
        m_fire    = m_ready && (state_q == ST_UNLOAD);
        drop_done = core_done && (flush_q != 2'd0);
        word_mode = (idx_q == '0) ? s_decrypt : dec_q;
        blk_word  = din_q;
        blk_word[BLK_W-1-int'(idx_q)*WORD_W -: WORD_W] = s_data;
    end

    // count of results still owed by the core for launches that were aborted;
    // each one swallows the next core_done so it cannot complete a later block
    always_comb begin
        flush_d = flush_q;
        if (drop_done) begin
            flush_d = flush_q - 2'd1;
        end
        if (clr && ((state_q == ST_START) ||
                    ((state_q == ST_WAIT) && !(core_done && !drop_done)))) begin
            if (flush_d != 2'd3) begin
                flush_d = flush_d + 2'd1;
            end
        end
    end

    // next state and datapath updates; clr overrides everything else
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        din_d   = din_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
`ifdef AES_CBC_EN
        chain_d = chain_q;
`endif
        if (clr) begin
            state_d = ST_LOAD;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
`ifdef AES_CBC_EN
                    if (iv_we && (idx_q == '0)) begin
                        chain_d = iv_in;
                    end
`endif
                    if (s_fire) begin
                        din_d = blk_word;
                        dec_d = word_mode;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = ST_START;
`ifdef AES_CBC_EN
                            // encrypt whitens the plaintext with the previous ciphertext
                            if (!word_mode) begin
                                din_d = blk_word ^ chain_q;
                            end
`endif
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_START: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done && !drop_done) begin
`ifdef AES_CBC_EN
                        if (dec_q) begin
                            out_d   = core_dout ^ chain_q;
                            chain_d = din_q;
                        end else begin
                            out_d   = core_dout;
                            chain_d = core_dout;
                        end
`else
                        out_d = core_dout;
`endif
                        state_d = ST_UNLOAD;
                    end
                end
                ST_UNLOAD: begin
                    if (m_fire) begin
                        out_d = out_q << WORD_W;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = ST_LOAD;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            din_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            flush_q <= 2'd0;
`ifdef AES_CBC_EN
            chain_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            flush_q <= flush_d;
`ifdef AES_CBC_EN
            chain_q <= chain_d;
`endif
        end
    end

    assign s_ready      = (state_q == ST_LOAD);
    assign m_valid      = (state_q == ST_UNLOAD);
    assign core_start   = (state_q == ST_START);
    assign m_data       = out_q[BLK_W-1 -: WORD_W];
    assign core_decrypt = dec_q;
    assign core_din     = din_q;
    assign blk_count    = cnt_q;

endmodule

// File: tb/tb_aes_stream_sequencer.sv
// Bench for aes_stream_sequencer: 32-bit word instance driven by a randomised
// source/sink against a stream-level reference, plus a 64-bit word instance.
`timescale 1ns/1ps
module tb_aes_stream_sequencer;

    localparam int WW  = 32;
    localparam int BW  = 128;
    localparam int CW  = 16;
    localparam int NW  = BW / WW;
    localparam int LAT = 10;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] TOYK = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    int total = 0;
    int bad   = 0;

    logic          clk;
    logic          rst_n, clr;
    logic [WW-1:0] s_data;
    logic          s_decrypt, s_valid, s_ready;
    logic [WW-1:0] m_data;
    logic          m_valid, m_ready;
    logic          core_start, core_decrypt, core_done;
    logic [BW-1:0] core_din, core_dout;
    logic [CW-1:0] blk_count;
    logic [BW-1:0] iv_in;
    logic          iv_we;

    logic [63:0]   s_data_w, m_data_w;
    logic          s_decrypt_w, s_valid_w, s_ready_w, m_valid_w, m_ready_w;
    logic          core_start_w, core_decrypt_w, core_done_w;
    logic [BW-1:0] core_din_w, core_dout_w;
    logic [CW-1:0] blk_count_w;

    aes_stream_sequencer #(.WORD_W(WW), .BLK_W(BW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_data(s_data), .s_decrypt(s_decrypt), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
`ifdef AES_CBC_EN
        .iv_in(iv_in), .iv_we(iv_we),
`endif
        .core_start(core_start), .core_decrypt(core_decrypt), .core_din(core_din),
        .core_done(core_done), .core_dout(core_dout), .blk_count(blk_count)
    );

    aes_stream_sequencer #(.WORD_W(64), .BLK_W(BW), .CNT_W(CW)) dut_w (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .s_data(s_data_w), .s_decrypt(s_decrypt_w), .s_valid(s_valid_w), .s_ready(s_ready_w),
        .m_data(m_data_w), .m_valid(m_valid_w), .m_ready(m_ready_w),
`ifdef AES_CBC_EN
        .iv_in('0), .iv_we(1'b0),
`endif
        .core_start(core_start_w), .core_decrypt(core_decrypt_w), .core_din(core_din_w),
        .core_done(core_done_w), .core_dout(core_dout_w), .blk_count(blk_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core behaviour: FIPS-197 C.1 known answer, otherwise an invertible stand-in
    function automatic logic [127:0] ref_core(input logic [127:0] d, input logic dec);
        logic [127:0] t;
        if (!dec && d == PT) return CT;
        if (dec && d == CT) return PT;
        if (!dec) return {d[94:0], d[127:95]} ^ TOYK;
        t = d ^ TOYK;
        return {t[32:0], t[127:33]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    // pipelined core models, LAT cycles from start to done
    typedef struct { int due; logic [127:0] res; } op_t;
    op_t ops[$];
    op_t ops_w[$];
    int  cyc = 0;
    int  cyc_w = 0;
    int  n_start = 0;

    always @(negedge clk) begin
        op_t o;
        cyc++;
        core_done = 1'b0;
        if (ops.size() > 0 && ops[0].due == cyc) begin
            core_done = 1'b1;
            core_dout = ops[0].res;
            void'(ops.pop_front());
        end
        if (core_start) begin
            n_start++;
            o.due = cyc + LAT;
            o.res = ref_core(core_din, core_decrypt);
            ops.push_back(o);
        end
    end

    always @(negedge clk) begin
        op_t o;
        cyc_w++;
        core_done_w = 1'b0;
        if (ops_w.size() > 0 && ops_w[0].due == cyc_w) begin
            core_done_w = 1'b1;
            core_dout_w = ops_w[0].res;
            void'(ops_w.pop_front());
        end
        if (core_start_w) begin
            o.due = cyc_w + LAT;
            o.res = ref_core(core_din_w, core_decrypt_w);
            ops_w.push_back(o);
        end
    end

    // stream-level reference: blocks in, expected output words out
    typedef struct { logic [WW-1:0] w; logic dec; } src_t;
    src_t          src_q[$];
    logic [WW-1:0] exp_q[$];
    logic [127:0]  part_blk = '0;
    int            part_cnt = 0;
    logic          part_dec = 1'b0;
    logic [127:0]  chain_m = '0;
    logic [127:0]  chain_bak = '0;
    int            gap_pct = 0;

    task automatic complete_blk(input logic [127:0] b, input logic d);
        logic [127:0] r;
        chain_bak = chain_m;
`ifdef AES_CBC_EN
        if (!d) begin
            r = ref_core(b ^ chain_m, 1'b0);
            chain_m = r;
        end else begin
            r = ref_core(b, 1'b1) ^ chain_m;
            chain_m = b;
        end
`else
        r = ref_core(b, d);
`endif
        for (int k = 0; k < NW; k++) exp_q.push_back(r[BW-1-k*WW -: WW]);
    endtask

    task automatic take_word(input logic [WW-1:0] w, input logic d);
        if (part_cnt == 0) part_dec = d;
        part_blk[BW-1-part_cnt*WW -: WW] = w;
        part_cnt++;
        if (part_cnt == NW) begin
            complete_blk(part_blk, part_dec);
            part_cnt = 0;
        end
    endtask

    // source: presents queued words with random gaps
    always @(negedge clk) begin
        if (src_q.size() > 0 && rst_n && !clr && $urandom_range(99) >= gap_pct) begin
            s_valid   = 1'b1;
            s_data    = src_q[0].w;
            s_decrypt = src_q[0].dec;
            if (s_ready) begin
                take_word(src_q[0].w, src_q[0].dec);
                void'(src_q.pop_front());
            end
        end else begin
            s_valid   = 1'b0;
            s_data    = $urandom;
            s_decrypt = 1'($urandom_range(1));
        end
    end

    // sink: random backpressure, word compare, hold check, block assembly
    int            ready_pct = 100;
    int            force_req = 0;
    int            hold_cnt = 0;
    int            sink_word = 0;
    logic          prev_stall = 1'b0;
    logic [WW-1:0] prev_data = '0;
    logic [127:0]  got_cur = '0;
    logic [127:0]  got_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            sink_word  = 0;
            prev_stall = 1'b0;
            m_ready    = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("m_valid_hold", 128'(m_valid), 128'(1));
                chk("m_data_hold", 128'(m_data), 128'(prev_data));
            end
            if (force_req != 0 && m_valid && sink_word == 1) begin
                hold_cnt  = 3;
                force_req = 0;
            end
            if (hold_cnt > 0) begin
                m_ready = 1'b0;
                hold_cnt--;
            end else begin
                m_ready = ($urandom_range(99) < ready_pct);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", 128'(m_data), 128'hx);
                else chk("m_data", 128'(m_data), 128'(exp_q.pop_front()));
                got_cur[BW-1-sink_word*WW -: WW] = m_data;
                sink_word++;
                if (sink_word == NW) begin
                    got_q.push_back(got_cur);
                    sink_word = 0;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic push_words(input logic [127:0] b, input logic d, input int cnt);
        src_t e;
        for (int k = 0; k < cnt; k++) begin
            e.w   = b[BW-1-k*WW -: WW];
            e.dec = (k == 0) ? d : 1'($urandom_range(1));
            src_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail_to(nm);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input int s0, input string nm);
        int t;
        t = 0;
        while (n_start == s0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_to(nm);
    endtask

    task automatic set_iv(input logic [127:0] v);
`ifdef AES_CBC_EN
        @(negedge clk);
        iv_in = v;
        iv_we = 1'b1;
        @(negedge clk);
        iv_we   = 1'b0;
        chain_m = v;
`else
        iv_in = v;
`endif
    endtask

    typedef struct { logic [127:0] blk; logic dec; logic [127:0] exp; } vec_t;
    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, g0, cnt_exp, seen, t;
        logic [127:0] b, c1, c2, ptv, ctv;

        vt[0] = '{PT, 1'b0, CT};
        vt[1] = '{CT, 1'b1, PT};
        vt[2] = '{128'h0, 1'b0, TOYK};
        vt[3] = '{TOYK, 1'b1, 128'h0};
        vt[4] = '{128'h1, 1'b0, 128'h0f1e2d3c4b5a69788796a5b6c3d2e1f0};

        rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; s_decrypt = 1'b0;
        m_ready = 1'b0; core_done = 1'b0; core_dout = '0; iv_in = '0; iv_we = 1'b0;
        s_valid_w = 1'b0; s_data_w = '0; s_decrypt_w = 1'b0; m_ready_w = 1'b0;
        core_done_w = 1'b0; core_dout_w = '0;
        cnt_exp = 0;

        repeat (3) @(negedge clk);
        chk("rst_s_ready", 128'(s_ready), 128'(1));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_core_start", 128'(core_start), 128'(0));
        chk("rst_core_decrypt", 128'(core_decrypt), 128'(0));
        chk("rst_core_din", core_din, 128'(0));
        chk("rst_m_data", 128'(m_data), 128'(0));
        chk("rst_blk_count", 128'(blk_count), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed vectors, including FIPS-197 C.1 both directions
        for (int i = 0; i < 5; i++) begin
            set_iv('0);
            s0 = n_start;
            g0 = got_q.size();
            push_words(vt[i].blk, vt[i].dec, NW);
            wait_idle("vec_idle");
            cnt_exp++;
            if (got_q.size() == g0 + 1) chk("vec_out", got_q[$], vt[i].exp);
            else chk("vec_blocks", 128'(got_q.size()), 128'(g0 + 1));
            chk("vec_starts", 128'(n_start - s0), 128'(1));
            chk("vec_blk_count", 128'(blk_count), 128'(cnt_exp));
        end

        // random data and modes with source gaps and sink backpressure
        gap_pct = 40; ready_pct = 50; force_req = 1;
        set_iv('0);
        push_words(PT, 1'b0, NW);
        for (int i = 0; i < 20; i++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            push_words(b, 1'($urandom_range(1)), NW);
        end
        wait_idle("rand_idle");
        cnt_exp += 21;
        chk("rand_blk_count", 128'(blk_count), 128'(cnt_exp));
        chk("forced_stall_seen", 128'(force_req), 128'(0));
        gap_pct = 0; ready_pct = 100;

        // abort after two words, then a full block
        set_iv('0);
        g0 = got_q.size();
        push_words(128'hdeadbeef_01234567_89abcdef_cafef00d, 1'b1, 2);
        t = 0;
        while (src_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) fail_to("clr_load_words");
        @(negedge clk);
        clr = 1'b1;
        part_cnt = 0;
        @(negedge clk);
        clr = 1'b0;
        b = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        push_words(b, 1'b0, NW);
        wait_idle("clr_load_idle");
        cnt_exp++;
        chk("clr_load_blocks", 128'(got_q.size()), 128'(g0 + 1));
        chk("clr_load_out", got_q[$], ref_core(b, 1'b0));
        chk("clr_load_blk_count", 128'(blk_count), 128'(cnt_exp));

        // abort in WAIT: the stale core_done must not complete the next block
        set_iv('0);
        g0 = got_q.size();
        s0 = n_start;
        push_words(128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0, 1'b0, NW);
        wait_start(s0, "clr_wait_start");
        repeat (2) @(negedge clk);
        clr = 1'b1;
        for (int k = 0; k < NW; k++) if (exp_q.size() > 0) void'(exp_q.pop_back());
        chain_m = chain_bak;
        @(negedge clk);
        clr = 1'b0;
        b = 128'h0badf00d_12345678_9abcdef0_13579bdf;
        push_words(b, 1'b0, NW);
        wait_idle("clr_wait_idle");
        repeat (LAT) @(negedge clk);
        cnt_exp++;
        chk("clr_wait_blocks", 128'(got_q.size()), 128'(g0 + 1));
        chk("clr_wait_out", got_q[$], ref_core(b, 1'b0));
        chk("clr_wait_blk_count", 128'(blk_count), 128'(cnt_exp));

        // reset while waiting on the core
        s0 = n_start;
        push_words(128'h77777777_66666666_55555555_44444444, 1'b1, NW);
        wait_start(s0, "rst_wait_start");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        part_cnt = 0;
        chain_m = '0;
        cnt_exp = 0;
        @(negedge clk);
        chk("rst_wait_m_valid", 128'(m_valid), 128'(0));
        chk("rst_wait_blk_count", 128'(blk_count), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        chk("rst_wait_no_output", 128'(seen), 128'(0));
        chk("rst_wait_blk_count_after", 128'(blk_count), 128'(0));

`ifdef AES_CBC_EN
        // CBC: identical plaintext blocks give different ciphertexts; decrypt recovers them
        set_iv('0);
        g0 = got_q.size();
        push_words(PT, 1'b0, NW);
        push_words(PT, 1'b0, NW);
        wait_idle("cbc_enc_idle");
        c1 = got_q[g0];
        c2 = got_q[g0 + 1];
        chk("cbc_first_ct", c1, CT);
        chk("cbc_second_differs", 128'(c1 != c2), 128'(1));
        set_iv('0);
        g0 = got_q.size();
        push_words(c1, 1'b1, NW);
        push_words(c2, 1'b1, NW);
        wait_idle("cbc_dec_idle");
        chk("cbc_dec_first", got_q[g0], PT);
        chk("cbc_dec_second", got_q[g0 + 1], PT);
`endif

        // 64-bit word instance: FIPS vector
        ptv = PT;
        ctv = CT;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_valid_w = 1'b1;
            s_data_w = ptv[127-64*k -: 64];
            s_decrypt_w = 1'b0;
            t = 0;
            while (!s_ready_w && t < 100) begin @(negedge clk); t++; end
            if (t >= 100) fail_to("w64_load");
        end
        @(negedge clk);
        s_valid_w = 1'b0;
        m_ready_w = 1'b1;
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (!m_valid_w && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) fail_to("w64_unload");
            chk("w64_word", 128'(m_data_w), 128'(ctv[127-64*k -: 64]));
            @(negedge clk);
        end
        @(negedge clk);
        chk("w64_blk_count", 128'(blk_count_w), 128'(1));
        chk("w64_m_valid_done", 128'(m_valid_w), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
